store_trace_fifo: RTL and testbench
===================================

# store_trace_fifo

- Captures every data-memory store retired by the pipelined CPU (`sccomp`): PC, address, write data, byte-enables.
- Buffers entries in a first-word-fall-through FIFO and drains them over a valid/ready handshake to a downstream consumer (UART dumper or simulation checker).
- Counts stores dropped while the FIFO is full, so store traffic can be checked cycle-exactly without stalling the CPU.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of `drop_cnt`
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `st_valid`  in  1  one store retires this cycle (from CPU MEM stage)
- `st_pc`  in  32  PC of the store
- `st_addr`  in  32  byte address (CPU `Addr_out`)
- `st_data`  in  32  store data (CPU `Data_out`), unaligned in low bits
- `st_dmtype`  in  3  access size (CPU `DMType_out`)
- `out_valid`  out  1  head entry present
- `out_ready`  in  1  consumer accepts head
- `out_pc`  out  32  head PC
- `out_addr`  out  32  head address, word-aligned (`addr & ~3`)
- `out_data`  out  32  head data, shifted into byte lanes
- `out_be`  out  4  head byte enables
- `out_err`  out  1  head entry misaligned or illegal dmtype
- `count`  out  log2(DEPTH)+1  current occupancy
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`
- `drop_cnt`  out  CNT_W  stores lost while full; saturating

## Operation
- **Encode stage (combinational, before write):**
  - dmtype 000: word; `be=1111`, `data=st_data`.
  - dmtype 001 or 010: half; `be=0011<<(2*addr[1])`, `data=st_data[15:0]<<(16*addr[1])`.
  - dmtype 011 or 100: byte; `be=0001<<addr[1:0]`, `data=st_data[7:0]<<(8*addr[1:0])`.
  - dmtype 101–111, word with `addr[1:0]≠0`, or half with `addr[0]=1`: `err=1`, `be=0000`, `data=st_data` unshifted.
  - Erroneous entries are still pushed.
- **Push:** `st_valid && (!full || pop)`. Entry written at `wr_ptr`; `wr_ptr` wraps modulo DEPTH.
- **Pop:** `out_valid && out_ready`. `rd_ptr` advances and wraps modulo DEPTH.
- **Drop:** `st_valid && full && !pop`. Entry discarded; `drop_cnt` increments, holds at all-ones.
- **Count:** `count` updates +1 / −1 / 0 from push and pop. Simultaneous push and pop leaves `count` unchanged, both when full and otherwise.
- **Empty:** push while empty is accepted; no pop is possible that cycle.
- **Pointers:** carry an extra wrap bit; full/empty derive from the registered `count`.
- `out_*` present storage at `rd_ptr` (FWFT); head contents are undefined when `out_valid=0`.

## Timing
- **Reset:** asynchronous assert clears `wr_ptr`, `rd_ptr`, `count` and `drop_cnt`, and sets `out_valid=0`, `out_pc/addr/data=0`, `out_be=0`, `out_err=0`, `empty=1`, `full=0`.
- **Reset mid-operation:** all stored entries are lost. Deassertion is synchronised externally.
- **Latency:** a store pushed at edge N is visible on `out_*` with `out_valid=1` after edge N (cycle N+1).
- **Throughput:** one push and one pop per cycle, sustained.
- **Handshake:**
  - `out_valid` stays high until popped.
  - `out_*` are stable while `out_valid && !out_ready`.
  - The consumer may hold `out_ready` high continuously.
- `full` and `empty` are registered and change one cycle after the causing edge, together with `count`.
- No input is registered before encode. The CPU guarantees `st_*` are stable around the edge.

## Configuration
- `STORE_TRACE_PC_EN`:
  - **Defined:** `st_pc` is stored per entry and driven on `out_pc`.
  - **Undefined:** PC storage is not synthesised, `out_pc` is tied to 0, and `st_pc` is ignored. Entry width drops by 32 bits.

## Test plan
- **Reset:** reset, then push word `st_addr=0x10`, `st_data=0xDEADBEEF`, `dmtype=000`. Expect `out_valid=1` next cycle, `out_addr=0x10`, `out_data=0xDEADBEEF`, `out_be=1111`, `out_err=0`.
- **Byte lanes:**
  - Byte store `addr=0x13`, `data=0x000000AB`, `dmtype=011` → `out_addr=0x10`, `out_data=0xAB000000`, `out_be=1000`.
  - Half store `addr=0x22`, `data=0x1234`, `dmtype=001` → `out_data=0x12340000`, `out_be=1100`.
- **Errors:**
  - Word store at `addr=0x06` → `out_err=1`, `out_be=0000`.
  - `dmtype=111` → `out_err=1`.
- **Overflow:** with `out_ready=0`, push DEPTH+3 stores → `full=1`, `count=DEPTH`, `drop_cnt=3`. Then drain all → first DEPTH entries in order, `empty=1`.
- **Full with simultaneous push/pop:** hold full, then push and pop in the same cycle for 5 cycles → `count` stays DEPTH, `drop_cnt` unchanged, order preserved across pointer wrap.
- **Reset mid-operation:** assert `rst` mid-stream with 7 entries queued → `out_valid=0`, `count=0`, `drop_cnt=0` immediately (asynchronously). With `STORE_TRACE_PC_EN` undefined, `out_pc` is always 0.

Source files
------------

// File: rtl/store_trace_fifo.sv
// store_trace_fifo: FWFT trace buffer of retired CPU stores with byte-lane encode and saturating drop counter.
// Define STORE_TRACE_PC_EN to store st_pc per entry and drive it on out_pc.
module store_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         st_valid,
  input  logic [31:0]                  st_pc,
  input  logic [31:0]                  st_addr,
  input  logic [31:0]                  st_data,
  input  logic [2:0]                   st_dmtype,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_addr,
  output logic [31:0]                  out_data,
  output logic [3:0]                   out_be,
  output logic                         out_err,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic [CNT_W-1:0]             drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 30 + 32 + 4 + 1;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic word, half, byt, err, push, pop, drop;
  logic [3:0] be;
  logic [31:0] data;
  assign word = st_dmtype == 3'd0;
  assign half = st_dmtype == 3'd1 || st_dmtype == 3'd2;
  assign byt  = st_dmtype == 3'd3 || st_dmtype == 3'd4;
  assign err  = st_dmtype > 3'd4 || (word && st_addr[1:0] != 2'd0) || (half && st_addr[0]);
  assign be   = err ? 4'b0000 : word ? 4'b1111 :
                half ? 4'b0011 << {st_addr[1], 1'b0} : 4'b0001 << st_addr[1:0];
  assign data = (err || word) ? st_data :
                half ? {16'b0, st_data[15:0]} << {st_addr[1], 4'b0} :
                {24'b0, st_data[7:0]} << {st_addr[1:0], 3'b0};
  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = st_valid && (!full || pop);
  assign drop      = st_valid && full && !pop;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {st_addr[31:2], data, be, err};
  assign head     = mem[rd_ptr[AW-1:0]];
  // Head is forced to zero while empty so reset presents all-zero outputs.
  assign out_addr = out_valid ? {head[EW-1:37], 2'b00} : '0;
  assign out_data = out_valid ? head[36:5] : '0;
  assign out_be   = out_valid ? head[4:1] : '0;
  assign out_err  = out_valid ? head[0] : 1'b0;
`ifdef STORE_TRACE_PC_EN
  logic [31:0] pc_mem [DEPTH];
  always_ff @(posedge clk)
    if (push) pc_mem[wr_ptr[AW-1:0]] <= st_pc;
  assign out_pc = out_valid ? pc_mem[rd_ptr[AW-1:0]] : '0;
`else
  logic unused_pc;
  assign unused_pc = ^st_pc;
  assign out_pc = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_store_trace_fifo.sv
// tb_store_trace_fifo: directed self-checking bench for store_trace_fifo with a small queue model.
module tb_store_trace_fifo;
  typedef struct {
    logic [31:0] pc, addr, data;
    logic [3:0]  be;
    logic        err;
  } ent_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        st_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] st_pc = '0, st_addr = '0, st_data = '0;
  logic [2:0]  st_dmtype = '0;
  logic        out_valid, out_err, full, empty;
  logic [31:0] out_pc, out_addr, out_data;
  logic [3:0]  out_be;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
  int n_checks = 0, n_errors = 0, exp_drop = 0;
  ent_t q[$];
  store_trace_fifo #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_pc(st_pc), .st_addr(st_addr),
    .st_data(st_data), .st_dmtype(st_dmtype), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
    .out_err(out_err), .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic ent_t mk(input logic [31:0] pc, addr, data, input logic [3:0] be, input logic err);
    ent_t e;
`ifdef STORE_TRACE_PC_EN
    e.pc = pc;
`else
    e.pc = 32'h0;
`endif
    e.addr = addr; e.data = data; e.be = be; e.err = err;
    return e;
  endfunction
  // One clock: check head against the model, apply inputs, advance the model, check counters.
  task automatic cycle(input logic v, input logic [31:0] pc, addr, data, input logic [2:0] dm,
                       input logic rdy, input ent_t e);
    logic pop_m, push_m;
    st_valid = v; st_pc = pc; st_addr = addr; st_data = data; st_dmtype = dm; out_ready = rdy;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_addr", out_addr, q[0].addr);
      check("out_data", out_data, q[0].data);
      check("out_be", 32'(out_be), 32'(q[0].be));
      check("out_err", 32'(out_err), 32'(q[0].err));
    end
    pop_m  = rdy && q.size() != 0;
    push_m = v && (q.size() < 16 || pop_m);
    if (v && !push_m) exp_drop++;
    @(posedge clk); #1;
    if (pop_m) void'(q.pop_front());
    if (push_m) q.push_back(e);
    st_valid = 1'b0; out_ready = 1'b0;
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == 16));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
  endtask
  task automatic idle_pop();
    cycle(1'b0, '0, '0, '0, 3'd0, 1'b1, mk('0, '0, '0, '0, 1'b0));
  endtask
  initial begin
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst count", 32'(count), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst out_addr", out_addr, 32'd0);
    check("rst out_be", 32'(out_be), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 32'h400, 32'h10, 32'hDEADBEEF, 3'd0, 1'b0, mk(32'h400, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0));
    idle_pop();
    cycle(1'b1, 32'h404, 32'h13, 32'h000000AB, 3'd3, 1'b0, mk(32'h404, 32'h10, 32'hAB000000, 4'h8, 1'b0));
    idle_pop();
    cycle(1'b1, 32'h408, 32'h22, 32'h00001234, 3'd1, 1'b0, mk(32'h408, 32'h20, 32'h12340000, 4'hC, 1'b0));
    idle_pop();
    cycle(1'b1, 32'h40C, 32'h06, 32'h11223344, 3'd0, 1'b0, mk(32'h40C, 32'h04, 32'h11223344, 4'h0, 1'b1));
    idle_pop();
    cycle(1'b1, 32'h410, 32'h30, 32'h55667788, 3'd7, 1'b0, mk(32'h410, 32'h30, 32'h55667788, 4'h0, 1'b1));
    idle_pop();
    cycle(1'b1, 32'h414, 32'h41, 32'h000000CD, 3'd4, 1'b0, mk(32'h414, 32'h40, 32'h0000CD00, 4'h2, 1'b0));
    cycle(1'b1, 32'h418, 32'h43, 32'h0000BEEF, 3'd2, 1'b0, mk(32'h418, 32'h40, 32'h0000BEEF, 4'h0, 1'b1));
    idle_pop();
    idle_pop();
    for (int i = 0; i < 19; i++)
      cycle(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 32'hA000 + 32'(i), 3'd0, 1'b0,
            mk(32'h1000 + 32'(i), 32'(i * 4), 32'hA000 + 32'(i), 4'hF, 1'b0));
    check("ovf full", 32'(full), 32'd1);
    check("ovf count", 32'(count), 32'd16);
    check("ovf drop", 32'(drop_cnt), 32'd3);
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 32'h2000 + 32'(k), 32'h100 + 32'(k * 4), 32'hB000 + 32'(k), 3'd0, 1'b1,
            mk(32'h2000 + 32'(k), 32'h100 + 32'(k * 4), 32'hB000 + 32'(k), 4'hF, 1'b0));
    check("pp count", 32'(count), 32'd16);
    check("pp drop", 32'(drop_cnt), 32'd3);
    for (int i = 0; i < 16; i++) idle_pop();
    check("drain empty", 32'(empty), 32'd1);
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 32'h3000 + 32'(i), 32'h200 + 32'(i * 4), 32'hC000 + 32'(i), 3'd0, 1'b0,
            mk(32'h3000 + 32'(i), 32'h200 + 32'(i * 4), 32'hC000 + 32'(i), 4'hF, 1'b0));
    check("pre-rst count", 32'(count), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("arst out_valid", 32'(out_valid), 32'd0);
    check("arst count", 32'(count), 32'd0);
    check("arst drop", 32'(drop_cnt), 32'd0);
    check("arst empty", 32'(empty), 32'd1);
    check("arst out_data", out_data, 32'd0);
    check("arst out_pc", out_pc, 32'd0);
    q.delete();
    exp_drop = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 32'h5000, 32'h50, 32'h0BADF00D, 3'd0, 1'b0, mk(32'h5000, 32'h50, 32'h0BADF00D, 4'hF, 1'b0));
    idle_pop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
